// File: rtl/circ_buf_pkg.sv
// circ_buf_pkg: shared width and modulo-pointer helpers for the circular write buffer
package circ_buf_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit modulo so non-power-of-two depths wrap correctly
    function automatic int mod_add(input int ptr, input int n, input int depth);
        return (ptr + n) % depth;
    endfunction

endpackage

// File: rtl/buf_wr_window.sv
// buf_wr_window: one-hot-run write-enable mask of WRITE_SIZE slots starting at wr_ptr, wrapping
module buf_wr_window
    import circ_buf_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WRITE_SIZE = 2,
    localparam int PTR_W     = ptr_width(DEPTH)
) (
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic             push,
    output logic [DEPTH-1:0] we
);

    // Mark WRITE_SIZE consecutive slots, modulo DEPTH, only when a push happens
    always_comb begin
        we = '0;
        for (int j = 0; j < WRITE_SIZE; j++)
            we[PTR_W'(mod_add(int'(wr_ptr), j, DEPTH))] = push;
    end

endmodule

// File: rtl/circ_write_buffer.sv
// circ_write_buffer: circular buffer pushing WRITE_SIZE words and popping READ_SIZE words per handshake
module circ_write_buffer
    import circ_buf_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WIDTH      = 16,
    parameter int WRITE_SIZE = 2,
    parameter int READ_SIZE  = 1,
    localparam int PTR_W     = ptr_width(DEPTH),
    localparam int CNT_W     = cnt_width(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [WRITE_SIZE*WIDTH-1:0] wr_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [READ_SIZE*WIDTH-1:0]  rd_data,
    output logic [CNT_W-1:0]            count,
    output logic                        full,
    output logic                        empty
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] slot_data [DEPTH];
    logic [DEPTH-1:0] we;
    logic             push;
    logic             pop;

    // Which incoming word lands in a slot: its distance from wr_ptr, clamped when outside the window
    function automatic int win_idx(input int slot, input int base);
        int j;
        j = mod_add(slot, DEPTH - base, DEPTH);
        return (j < WRITE_SIZE) ? j : 0;
    endfunction

    // Room check uses registered count only, so a same-cycle pop never opens the write side
    assign wr_ready = (DEPTH - int'(count)) >= WRITE_SIZE;
    assign rd_valid = int'(count) >= READ_SIZE;
    assign full     = int'(count) == DEPTH;
    assign empty    = count == '0;
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    buf_wr_window #(
        .DEPTH      (DEPTH),
        .WRITE_SIZE (WRITE_SIZE)
    ) u_window (
        .wr_ptr (wr_ptr),
        .push   (push & ~flush),
        .we     (we)
    );

    // Route each incoming word to the storage slot it targets
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            slot_data[i] = wr_data[WIDTH*win_idx(i, int'(wr_ptr)) +: WIDTH];
    end

    // First-word fall-through read window starting at rd_ptr
    always_comb begin
        for (int k = 0; k < READ_SIZE; k++)
            rd_data[k*WIDTH +: WIDTH] = mem[PTR_W'(mod_add(int'(rd_ptr), k, DEPTH))];
    end

    // Pointers and occupancy; flush overrides both handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= PTR_W'(mod_add(int'(wr_ptr), WRITE_SIZE, DEPTH));
            if (pop)
                rd_ptr <= PTR_W'(mod_add(int'(rd_ptr), READ_SIZE, DEPTH));
            count <= CNT_W'(int'(count) + (push ? WRITE_SIZE : 0) - (pop ? READ_SIZE : 0));
        end
    end

    // Storage: only slots inside the active write window change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (we[i])
                    mem[i] <= slot_data[i];
        end
    end

endmodule

// File: tb/tb_circ_write_buffer.sv
// tb_circ_write_buffer: directed checks of fill, drain, wrap, concurrent push/pop, flush and async reset
module tb_circ_write_buffer;

    logic        clk = 0;
    logic        rst_n;
    logic        flush;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    circ_write_buffer #(
        .DEPTH(8), .WIDTH(16), .WRITE_SIZE(2), .READ_SIZE(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w0, input logic [15:0] w1);
        wr_valid = 1;
        wr_data  = {w1, w0};
        step();
        wr_valid = 0;
    endtask

    task automatic pop();
        rd_ready = 1;
        step();
        rd_ready = 0;
    endtask

    logic [15:0] fill_words [8] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044,
                                    16'h0055, 16'h0066, 16'h0077, 16'h0088};
    logic [15:0] wrap_words [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; flush = 0; wr_valid = 0; rd_ready = 0; wr_data = '0;
        #12;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        rst_n = 1;
        step();

        // Fill
        for (int i = 0; i < 4; i++) begin
            push(fill_words[2*i], fill_words[2*i+1]);
            check("fill_count", count, 2*(i+1));
        end
        check("fill_full", full, 1);
        check("fill_wr_ready", wr_ready, 0);
        push(16'hDEAD, 16'hBEEF);
        check("overfill_count", count, 8);
        check("overfill_head", rd_data, 16'h0011);
        check("overfill_wr_ptr", dut.wr_ptr, 0);

        // Drain order
        rd_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check("drain_data", rd_data, fill_words[i]);
            step();
        end
        check("drain_empty", empty, 1);
        check("drain_rd_valid", rd_valid, 0);
        check("drain_count", count, 0);
        step();
        check("underflow_count", count, 0);
        check("underflow_rd_ptr", dut.rd_ptr, 0);
        rd_ready = 0;

        // Wrap-around: move both pointers to 6, then push across the end of storage
        for (int i = 0; i < 3; i++) push(16'h0900 + 16'(i), 16'h0A00 + 16'(i));
        rd_ready = 1;
        repeat (6) step();
        rd_ready = 0;
        check("wrap_pre_wr_ptr", dut.wr_ptr, 6);
        check("wrap_pre_rd_ptr", dut.rd_ptr, 6);
        check("wrap_pre_count", count, 0);
        push(16'hAAAA, 16'hBBBB);
        check("wrap_wr_ptr", dut.wr_ptr, 0);
        check("wrap_mem7", dut.mem[7], 16'hBBBB);
        push(16'hCCCC, 16'hDDDD);
        check("wrap_mem0", dut.mem[0], 16'hCCCC);
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("wrap_data", rd_data, wrap_words[i]);
            step();
        end
        rd_ready = 0;
        check("wrap_rd_ptr", dut.rd_ptr, 2);

        // Simultaneous push/pop
        push(16'h0101, 16'h0202);
        push(16'h0303, 16'h0404);
        push(16'h0505, 16'h0606);
        check("pp_count6", count, 6);
        check("pp_head", rd_data, 16'h0101);
        rd_ready = 1;
        push(16'h1111, 16'h2222);
        check("pp_count7", count, 7);
        check("pp_head2", rd_data, 16'h0202);
        wr_valid = 1;
        wr_data  = {16'h7777, 16'h6666};
        check("pp_no_bypass", wr_ready, 0);
        step();
        wr_valid = 0;
        check("pp_pop_only", count, 6);
        check("pp_head3", rd_data, 16'h0303);
        step();
        rd_ready = 0;
        check("pp_count5", count, 5);

        // Flush priority
        flush = 1; wr_valid = 1; rd_ready = 1; wr_data = {16'hFFFF, 16'hEEEE};
        step();
        flush = 0; wr_valid = 0; rd_ready = 0;
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_wr_ptr", dut.wr_ptr, 0);
        check("flush_rd_ptr", dut.rd_ptr, 0);
        check("flush_mem2", dut.mem[2], 16'h0101);
        check("flush_mem3", dut.mem[3], 16'h0202);
        check("flush_rd_data", rd_data, 16'h1111);

        // Async reset mid-operation
        push(16'h3131, 16'h3232);
        push(16'h3333, 16'h3434);
        check("ar_count4", count, 4);
        #2;
        rst_n = 0;
        #1;
        check("ar_count", count, 0);
        check("ar_rd_valid", rd_valid, 0);
        check("ar_wr_ready", wr_ready, 1);
        check("ar_rd_data", rd_data, 0);
        #10;
        rst_n = 1;
        push(16'h5151, 16'h5252);
        check("ar_push_count", count, 2);
        check("ar_push_mem0", dut.mem[0], 16'h5151);
        check("ar_push_mem1", dut.mem[1], 16'h5252);
        check("ar_push_head", rd_data, 16'h5151);
        pop();
        check("ar_pop_head", rd_data, 16'h5252);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
